io_bus_arbiter: RTL and testbench

//  Two-master arbiter for the single-outstanding-per-cycle IO bus (dma_io_*) that feeds the

---
 rtl/io_bus_pkg.sv | 21 ++
 rtl/io_bus_arbiter_if.sv | 47 ++++
 rtl/io_arb_rr.sv | 30 +++
 rtl/io_bus_arbiter.sv | 81 ++++++++
 tb/tb_io_bus_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared IO bus constants, master ids and response tag type
package io_bus_pkg;

    localparam int IO_ADR_W  = 14;
    localparam int IO_DATA_W = 32;

    localparam logic [IO_ADR_W-1:0] SYS_LED_IO   = 14'h3F80;
    localparam logic [IO_ADR_W-1:0] SYS_GPI_IN   = 14'h3F81;
    localparam logic [IO_ADR_W-1:0] SYS_GPIO_OUT = 14'h3F84;
    localparam logic [IO_ADR_W-1:0] SYS_GPIO_IN  = 14'h3F85;
    localparam logic [IO_ADR_W-1:0] SYS_GPIO_EN  = 14'h3F86;

    localparam logic MID_CPU = 1'b0;
    localparam logic MID_DBG = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// rtl/io_bus_arbiter_if.sv - master-side handshakes and downstream IO bus of the arbiter
interface io_bus_arbiter_if;
    import io_bus_pkg::*;

    logic                 m0_req;
    logic                 m0_we;
    logic [IO_ADR_W-1:0]  m0_adr;
    logic [IO_DATA_W-1:0] m0_wdata;
    logic                 m0_gnt;
    logic                 m0_rvalid;
    logic [IO_DATA_W-1:0] m0_rdata;

    logic                 m1_req;
    logic                 m1_we;
    logic [IO_ADR_W-1:0]  m1_adr;
    logic [IO_DATA_W-1:0] m1_wdata;
    logic                 m1_gnt;
    logic                 m1_rvalid;
    logic [IO_DATA_W-1:0] m1_rdata;
    logic                 m1_lock;

    logic                 dma_io_we;
    logic [IO_ADR_W-1:0]  dma_io_wadr;
    logic [IO_DATA_W-1:0] dma_io_wdata;
    logic                 dma_io_radr_en;
    logic [IO_ADR_W-1:0]  dma_io_radr;
    logic [IO_DATA_W-1:0] dma_io_rdata;

    modport slave (
        input  m0_req, m0_we, m0_adr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_adr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr_en, dma_io_radr,
        input  dma_io_rdata
    );

    modport master (
        output m0_req, m0_we, m0_adr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_adr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr_en, dma_io_radr,
        output dma_io_rdata
    );

endinterface

// File: rtl/io_arb_rr.sv
// rtl/io_arb_rr.sv - combinational two-way round-robin pick with m1 burst override
module io_arb_rr (
    input  logic req0,
    input  logic req1,
    input  logic last_m1,
    input  logic lock,
    input  logic burst_ok,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            // a locked m1 burst outranks fairness until its budget is spent
            if (lock && burst_ok) begin
                gnt1 = 1'b1;
            end else if (last_m1) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-master IO bus arbiter with registered strobes and in-order read tags
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rst_n,
    io_bus_arbiter_if.slave  bus
);

    logic       last_m1;
    logic [3:0] burst_cnt;
    logic       burst_ok;
    logic       gnt0;
    logic       gnt1;
    logic       any_gnt;
    logic       sel_we;
    tag_t       tag1;
    tag_t       tag2;

    logic [IO_ADR_W-1:0]  sel_adr;
    logic [IO_DATA_W-1:0] sel_wdata;

    assign burst_ok = (burst_cnt < 4'(MAX_BURST));

    io_arb_rr u_rr (
        .req0     (bus.m0_req),
        .req1     (bus.m1_req),
        .last_m1  (last_m1),
        .lock     (bus.m1_lock),
        .burst_ok (burst_ok),
        .gnt0     (gnt0),
        .gnt1     (gnt1)
    );

    assign any_gnt   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? bus.m1_we    : bus.m0_we;
    assign sel_adr   = gnt1 ? bus.m1_adr   : bus.m0_adr;
    assign sel_wdata = gnt1 ? bus.m1_wdata : bus.m0_wdata;

    // grants are masked during reset only at the boundary; internal state is already held
    assign bus.m0_gnt = gnt0 & rst_n;
    assign bus.m1_gnt = gnt1 & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_m1            <= MID_DBG;
            burst_cnt          <= '0;
            bus.dma_io_we      <= 1'b0;
            bus.dma_io_radr_en <= 1'b0;
            bus.dma_io_wadr    <= '0;
            bus.dma_io_radr    <= '0;
            bus.dma_io_wdata   <= '0;
            tag1               <= '0;
            tag2               <= '0;
        end else begin
            if (any_gnt) begin
                last_m1          <= gnt1;
                bus.dma_io_wadr  <= sel_adr;
                bus.dma_io_radr  <= sel_adr;
                bus.dma_io_wdata <= sel_wdata;
            end
            if (gnt0 || !bus.m1_lock || !bus.m0_req) begin
                burst_cnt <= '0;
            end else if (gnt1) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
            bus.dma_io_we      <= any_gnt & sel_we;
            bus.dma_io_radr_en <= any_gnt & ~sel_we;
            tag1               <= '{valid: any_gnt & ~sel_we, id: gnt1};
            tag2               <= tag1;
        end
    end

    assign bus.m0_rvalid = tag2.valid && (tag2.id == MID_CPU);
    assign bus.m1_rvalid = tag2.valid && (tag2.id == MID_DBG);
    assign bus.m0_rdata  = bus.dma_io_rdata;
    assign bus.m1_rdata  = bus.dma_io_rdata;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - directed bench with per-cycle reference model for io_bus_arbiter
module tb_io_bus_arbiter;
    import io_bus_pkg::*;

    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] rdata_drv = 32'h0;

    always #5 clk = ~clk;

    io_bus_arbiter_if bus ();
    assign bus.dma_io_rdata = rdata_drv;

    io_bus_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int          m_last;
    int          m_cnt;
    logic [13:0] h_wadr;
    logic [13:0] h_radr;
    logic [31:0] h_wdata;
    bit          e_we [4];
    bit          e_re [4];
    int          e_rv [4];
    int          cyc = 0;
    int          gq [$];
    int          rvq [$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_last  = 1;
        m_cnt   = 0;
        h_wadr  = '0;
        h_radr  = '0;
        h_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            e_we[i] = 1'b0;
            e_re[i] = 1'b0;
            e_rv[i] = -1;
        end
    endtask

    function automatic int model_pick();
        if (bus.m0_req && bus.m1_req) begin
            if (bus.m1_lock && m_cnt < MAXB) return 1;
            return (m_last == 1) ? 0 : 1;
        end
        if (bus.m0_req) return 0;
        if (bus.m1_req) return 1;
        return -1;
    endfunction

    always @(negedge rst_n) reset_model();

    always @(negedge clk) begin : mon
        int g, s, s1;
        logic wg;
        s = cyc % 4;
        if (!rst_n) begin
            chk("rst_m0_gnt", bus.m0_gnt, 0);
            chk("rst_m1_gnt", bus.m1_gnt, 0);
            chk("rst_we", bus.dma_io_we, 0);
            chk("rst_radr_en", bus.dma_io_radr_en, 0);
            chk("rst_m0_rvalid", bus.m0_rvalid, 0);
            chk("rst_m1_rvalid", bus.m1_rvalid, 0);
            reset_model();
        end else begin
            g = model_pick();
            chk("m0_gnt", bus.m0_gnt, 32'(g == 0));
            chk("m1_gnt", bus.m1_gnt, 32'(g == 1));
            gq.push_back(bus.m0_gnt ? 0 : (bus.m1_gnt ? 1 : 2));
            chk("dma_io_we", bus.dma_io_we, e_we[s]);
            chk("dma_io_radr_en", bus.dma_io_radr_en, e_re[s]);
            chk("dma_io_wadr", bus.dma_io_wadr, h_wadr);
            chk("dma_io_radr", bus.dma_io_radr, h_radr);
            chk("dma_io_wdata", bus.dma_io_wdata, h_wdata);
            chk("m0_rvalid", bus.m0_rvalid, 32'(e_rv[s] == 0));
            chk("m1_rvalid", bus.m1_rvalid, 32'(e_rv[s] == 1));
            if (e_rv[s] == 0) chk("m0_rdata", bus.m0_rdata, rdata_drv);
            if (e_rv[s] == 1) chk("m1_rdata", bus.m1_rdata, rdata_drv);
            if (bus.m0_rvalid) rvq.push_back(0);
            if (bus.m1_rvalid) rvq.push_back(1);
            e_we[s] = 1'b0;
            e_re[s] = 1'b0;
            e_rv[s] = -1;
            if (g >= 0) begin
                wg      = (g == 1) ? bus.m1_we : bus.m0_we;
                s1      = (cyc + 1) % 4;
                e_we[s1] = wg;
                e_re[s1] = !wg;
                h_wadr  = (g == 1) ? bus.m1_adr : bus.m0_adr;
                h_radr  = h_wadr;
                h_wdata = (g == 1) ? bus.m1_wdata : bus.m0_wdata;
                if (!wg) e_rv[(cyc + 2) % 4] = g;
                m_last = g;
            end
            if (g == 0 || !bus.m1_lock || !bus.m0_req) m_cnt = 0;
            else if (g == 1) m_cnt = m_cnt + 1;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(bit req, bit we, logic [13:0] adr, logic [31:0] wd);
        bus.m0_req = req; bus.m0_we = we; bus.m0_adr = adr; bus.m0_wdata = wd;
    endtask

    task automatic set_m1(bit req, bit we, logic [13:0] adr, logic [31:0] wd);
        bus.m1_req = req; bus.m1_we = we; bus.m1_adr = adr; bus.m1_wdata = wd;
    endtask

    task automatic chk_seq(string name, int exp[]);
        chk({name, "_len"}, gq.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk(name, (i < gq.size()) ? gq[i] : 9, exp[i]);
    endtask

    initial begin
        int exp4[] = '{0, 1, 0, 1, 0, 1};
        int exp5[] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
        int exp5b[] = '{0, 1, 0, 1};
        reset_model();
        bus.m1_lock = 1'b0;
        set_m0(1'b1, 1'b1, SYS_GPIO_OUT, 32'h11);
        set_m1(1'b1, 1'b0, SYS_GPI_IN, 32'h0);
        repeat (3) step();

        // release with both requesting: m0 wins first, then strict alternation
        gq.delete();
        rst_n = 1'b1;
        repeat (6) step();
        chk_seq("alt_grants", exp4);
        set_m0(1'b0, 1'b0, 14'h0, 32'h0);
        set_m1(1'b0, 1'b0, 14'h0, 32'h0);
        repeat (2) step();

        // single write from m0
        set_m0(1'b1, 1'b1, SYS_LED_IO, 32'h5);
        @(negedge clk);
        chk("wr_m0_gnt", bus.m0_gnt, 1);
        chk("wr_m1_gnt", bus.m1_gnt, 0);
        step();
        set_m0(1'b0, 1'b0, 14'h0, 32'h0);
        @(negedge clk);
        chk("wr_we", bus.dma_io_we, 1);
        chk("wr_wadr", bus.dma_io_wadr, 32'h3F80);
        chk("wr_wdata", bus.dma_io_wdata, 32'h5);
        chk("wr_radr_en", bus.dma_io_radr_en, 0);
        step();
        @(negedge clk);
        chk("wr_we_drop", bus.dma_io_we, 0);
        step();

        // single read from m0, data returned two cycles after the request
        set_m0(1'b1, 1'b0, SYS_GPIO_IN, 32'h0);
        @(negedge clk);
        chk("rd_m0_gnt", bus.m0_gnt, 1);
        step();
        set_m0(1'b0, 1'b0, 14'h0, 32'h0);
        @(negedge clk);
        chk("rd_radr_en", bus.dma_io_radr_en, 1);
        chk("rd_radr", bus.dma_io_radr, 32'h3F85);
        chk("rd_early_rvalid", bus.m0_rvalid, 0);
        step();
        rdata_drv = 32'hA;
        @(negedge clk);
        chk("rd_m0_rvalid", bus.m0_rvalid, 1);
        chk("rd_m0_rdata", bus.m0_rdata, 32'hA);
        chk("rd_m1_rvalid", bus.m1_rvalid, 0);
        step();
        rdata_drv = 32'h0;
        step();

        // locked m1 bursts are capped, then lock release restores alternation
        gq.delete();
        bus.m1_lock = 1'b1;
        set_m0(1'b1, 1'b1, SYS_GPIO_EN, 32'h3);
        set_m1(1'b1, 1'b1, SYS_GPIO_OUT, 32'h7);
        repeat (9) step();
        chk_seq("burst_grants", exp5);
        gq.delete();
        bus.m1_lock = 1'b0;
        repeat (4) step();
        chk_seq("unlock_grants", exp5b);
        set_m0(1'b0, 1'b0, 14'h0, 32'h0);
        set_m1(1'b0, 1'b0, 14'h0, 32'h0);
        repeat (2) step();

        // interleaved reads, then reset while the last read is in flight
        rvq.delete();
        rdata_drv = 32'h1234;
        set_m0(1'b1, 1'b0, SYS_LED_IO, 32'h0);
        step();
        set_m0(1'b0, 1'b0, 14'h0, 32'h0);
        set_m1(1'b1, 1'b0, SYS_GPI_IN, 32'h0);
        step();
        set_m1(1'b0, 1'b0, 14'h0, 32'h0);
        set_m0(1'b1, 1'b0, SYS_GPIO_IN, 32'h0);
        step();
        set_m0(1'b0, 1'b0, 14'h0, 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("pulse_radr_en", bus.dma_io_radr_en, 0);
        chk("pulse_we", bus.dma_io_we, 0);
        chk("pulse_m0_rvalid", bus.m0_rvalid, 0);
        chk("pulse_m1_rvalid", bus.m1_rvalid, 0);
        #1;
        rst_n = 1'b1;
        repeat (4) step();
        chk("rv_count", rvq.size(), 2);
        chk("rv_first", (rvq.size() > 0) ? rvq[0] : 9, 0);
        chk("rv_second", (rvq.size() > 1) ? rvq[1] : 9, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
